// File: rtl/fetch_lock_ctrl_if.sv
// Fetch-lock control bundle between the IF_ID pipeline register and its lock controller.
// The controller side uses modport master; the pipeline side uses modport slave.
interface fetch_lock_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic [4:0]        decRs1;
  logic [4:0]        decRs2;
  logic              decUsesRs2;
  logic [4:0]        aluRd;
  logic              aluIsLoad;
  logic              branchTaken;
  logic              icacheValid;
  logic [DATA_W-1:0] icacheData;
  logic              locker;
  logic              select;
  logic [DATA_W-1:0] nextInst;
  logic              ALUForwardCSL;
  logic              pcStall;
  logic              flush;
  logic [15:0]       stallCount;

  modport master (
    input  decRs1, decRs2, decUsesRs2, aluRd, aluIsLoad, branchTaken, icacheValid, icacheData,
    output locker, select, nextInst, ALUForwardCSL, pcStall, flush, stallCount
  );

  modport slave (
    output decRs1, decRs2, decUsesRs2, aluRd, aluIsLoad, branchTaken, icacheValid, icacheData,
    input  locker, select, nextInst, ALUForwardCSL, pcStall, flush, stallCount
  );
endinterface

// File: rtl/fetch_lock_ctrl.sv
// IF_ID lock controller: handles load-use stalls with a one-entry replay buffer,
// instruction-cache misses and branch flushes.
// Optional macro LOCK_STALL_COUNT_EN adds a saturating count of PC-stall cycles.
module fetch_lock_ctrl #(
  parameter int unsigned DATA_W = 32
) (
  input logic            clk,
  input logic            resetN,
  fetch_lock_ctrl_if.master bus
);

  typedef enum logic [2:0] {StRun, StMiss, StStall, StReplay, StFlush} state_e;

  state_e            state_q, state_d;
  logic              buf_valid_q;
  logic [DATA_W-1:0] next_inst_q;
  logic              hazard;
  logic              cap_en;
  logic              buf_clr;
  logic              locker;
  logic              select;
  logic              fwd;
  logic              pc_stall;
  logic              flush;

  // Load-use hazard between the ALU-stage load and the instruction sitting in IF_ID.
  assign hazard = bus.aluIsLoad && (bus.aluRd != 5'd0) &&
                  ((bus.aluRd == bus.decRs1) || (bus.decUsesRs2 && (bus.aluRd == bus.decRs2)));

  // Next state and output decode; branchTaken outranks hazard and miss everywhere.
  always_comb begin
    state_d = state_q;
    locker  = 1'b0;
    select  = 1'b0;
    fwd     = 1'b0;
    pc_stall = 1'b0;
    flush   = 1'b0;
    cap_en  = 1'b0;
    buf_clr = 1'b0;
    unique case (state_q)
      StRun: begin
        locker   = bus.icacheValid;
        pc_stall = !bus.icacheValid;
        if (bus.branchTaken) begin
          state_d = StFlush;
        end else if (hazard) begin
          locker   = 1'b0;
          pc_stall = 1'b1;
          cap_en   = bus.icacheValid;
          state_d  = StStall;
        end else if (!bus.icacheValid) begin
          state_d = StMiss;
        end
      end
      StMiss: begin
        // The cycle the fetch returns, IF_ID loads it and the PC moves on.
        locker   = bus.icacheValid && !bus.branchTaken;
        pc_stall = !locker;
        if (bus.branchTaken) begin
          state_d = StFlush;
        end else if (bus.icacheValid) begin
          state_d = StRun;
        end
      end
      StStall: begin
        pc_stall = 1'b1;
        cap_en   = !buf_valid_q && bus.icacheValid;
        state_d  = bus.branchTaken ? StFlush : StReplay;
      end
      StReplay: begin
        select   = buf_valid_q;
        locker   = !buf_valid_q && bus.icacheValid;
        fwd      = 1'b1;
        pc_stall = !buf_valid_q && !bus.icacheValid;
        buf_clr  = 1'b1;
        state_d  = bus.branchTaken ? StFlush : StRun;
      end
      StFlush: begin
        flush   = 1'b1;
        buf_clr = 1'b1;
        state_d = bus.branchTaken ? StFlush : StRun;
      end
      default: state_d = StRun;
    endcase
    // Outputs are forced quiet for as long as reset is held, not just at the edge.
    if (!resetN) begin
      locker   = 1'b0;
      select   = 1'b0;
      fwd      = 1'b0;
      pc_stall = 1'b0;
      flush    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Replay buffer; nextInst survives a flush, only the valid flag is dropped.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      buf_valid_q <= 1'b0;
      next_inst_q <= '0;
    end else if (cap_en) begin
      buf_valid_q <= 1'b1;
      next_inst_q <= bus.icacheData;
    end else if (buf_clr) begin
      buf_valid_q <= 1'b0;
    end
  end

  assign bus.locker        = locker;
  assign bus.select        = select;
  assign bus.ALUForwardCSL = fwd;
  assign bus.pcStall       = pc_stall;
  assign bus.flush         = flush;
  assign bus.nextInst      = next_inst_q;

`ifdef LOCK_STALL_COUNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles the PC is held.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stall_cnt_q <= '0;
    end else if (pc_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stallCount = stall_cnt_q;
`else
  assign bus.stallCount = '0;
`endif

endmodule

// File: tb/tb_fetch_lock_ctrl.sv
// Bench for fetch_lock_ctrl: directed scenarios plus randomized traffic checked against
// a behavioural model of the lock rules. Honours LOCK_STALL_COUNT_EN like the design.
module tb_fetch_lock_ctrl;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  fetch_lock_ctrl_if #(.DATA_W(DATA_W)) bus ();

  fetch_lock_ctrl #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Model: what the controller is doing this cycle, described by its effect.
  bit          flushing, waiting_fetch, holding, replaying;
  logic [31:0] held[$];       // pending replay instruction (0 or 1 entries)
  logic [31:0] m_next;        // last instruction captured for replay
  int          m_cnt;         // PC-stall cycles seen (saturating)
  bit          sel_seen;

  // Values observed in the most recent step.
  logic        o_lock, o_sel, o_fwd, o_pcs, o_fl;
  logic [31:0] o_next;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt();
`ifdef LOCK_STALL_COUNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic model_clear();
    flushing = 0; waiting_fetch = 0; holding = 0; replaying = 0;
    held.delete();
    m_next = '0;
    m_cnt = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_locker"}, 32'(bus.locker), 32'd0);
    chk({tag, "_select"}, 32'(bus.select), 32'd0);
    chk({tag, "_fwd"}, 32'(bus.ALUForwardCSL), 32'd0);
    chk({tag, "_pcstall"}, 32'(bus.pcStall), 32'd0);
    chk({tag, "_flush"}, 32'(bus.flush), 32'd0);
    chk({tag, "_nextinst"}, bus.nextInst, 32'd0);
    chk({tag, "_stallcnt"}, 32'(bus.stallCount), 32'd0);
  endtask

  // Called at a negedge; applies inputs, checks outputs, advances one clock, returns at negedge.
  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input bit u2,
                      input logic [4:0] rd, input bit ld, input bit bt, input bit iv,
                      input logic [31:0] data);
    bit hz, e_lock, e_sel, e_fwd, e_pcs, e_fl;
    bit n_flush, n_wait, n_hold, n_replay, grab, drop;
    bus.decRs1 = rs1; bus.decRs2 = rs2; bus.decUsesRs2 = u2;
    bus.aluRd = rd; bus.aluIsLoad = ld; bus.branchTaken = bt;
    bus.icacheValid = iv; bus.icacheData = data;
    #1;
    hz = ld && (rd != 0) && (rd == rs1 || (u2 && rd == rs2));
    {e_lock, e_sel, e_fwd, e_pcs, e_fl} = '0;
    {n_flush, n_wait, n_hold, n_replay, grab, drop} = '0;
    if (flushing) begin
      e_fl = 1; drop = 1; n_flush = bt;
    end else if (waiting_fetch) begin
      e_lock = iv && !bt; e_pcs = !e_lock;
      n_flush = bt; n_wait = !bt && !iv;
    end else if (holding) begin
      e_pcs = 1; grab = (held.size() == 0) && iv;
      n_flush = bt; n_replay = !bt;
    end else if (replaying) begin
      e_sel = held.size() != 0; e_lock = !e_sel && iv; e_fwd = 1;
      e_pcs = !e_sel && !iv; drop = 1; n_flush = bt;
    end else if (bt) begin
      e_lock = iv; e_pcs = !iv; n_flush = 1;
    end else if (hz) begin
      e_pcs = 1; grab = iv; n_hold = 1;
    end else begin
      e_lock = iv; e_pcs = !iv; n_wait = !iv;
    end
    o_lock = bus.locker; o_sel = bus.select; o_fwd = bus.ALUForwardCSL;
    o_pcs = bus.pcStall; o_fl = bus.flush; o_next = bus.nextInst;
    if (o_sel) sel_seen = 1;
    chk("locker", 32'(o_lock), 32'(e_lock));
    chk("select", 32'(o_sel), 32'(e_sel));
    chk("fwd", 32'(o_fwd), 32'(e_fwd));
    chk("pcstall", 32'(o_pcs), 32'(e_pcs));
    chk("flush", 32'(o_fl), 32'(e_fl));
    chk("nextinst", o_next, m_next);
    chk("stallcnt", 32'(bus.stallCount), 32'(exp_cnt()));
    chk("lock_sel_excl", 32'(o_lock & o_sel), 32'd0);
    @(posedge clk);
    if (grab) begin
      held.delete(); held.push_back(data); m_next = data;
    end
    if (drop) held.delete();
    if (e_pcs && m_cnt < 65535) m_cnt++;
    flushing = n_flush; waiting_fetch = n_wait; holding = n_hold; replaying = n_replay;
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0013);
  endtask

  task automatic do_reset(input string tag);
    resetN = 1'b0;
    #1;
    check_all_zero(tag);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    int guard;
    model_clear();
    sel_seen = 0;
    bus.decRs1 = '0; bus.decRs2 = '0; bus.decUsesRs2 = 0; bus.aluRd = '0;
    bus.aluIsLoad = 0; bus.branchTaken = 0; bus.icacheValid = 0; bus.icacheData = '0;
    resetN = 1'b1;
    @(negedge clk);
    do_reset("reset");

    // Three-cycle fetch miss from RUN.
    for (int i = 0; i < 3; i++) begin
      step(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("miss_locker", 32'(o_lock), 32'd0);
      chk("miss_pcstall", 32'(o_pcs), 32'd1);
    end
`ifdef LOCK_STALL_COUNT_EN
    chk("miss_count", 32'(bus.stallCount), 32'd3);
`else
    chk("miss_count", 32'(bus.stallCount), 32'd0);
`endif
    idle_step();
    chk("miss_return_locker", 32'(o_lock), 32'd1);

    // Load-use stall and replay.
    step(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 32'h00A0_0093);
    chk("lu_c0_locker", 32'(o_lock), 32'd0);
    chk("lu_c0_pcstall", 32'(o_pcs), 32'd1);
    step(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 32'h1111_1111);
    chk("lu_stall_pcstall", 32'(o_pcs), 32'd1);
    step(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 32'h2222_2222);
    chk("lu_replay_select", 32'(o_sel), 32'd1);
    chk("lu_replay_fwd", 32'(o_fwd), 32'd1);
    chk("lu_replay_nextinst", o_next, 32'h00A0_0093);
    idle_step();
    chk("lu_run_locker", 32'(o_lock), 32'd1);

    // x0 never causes a hazard.
    step(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0013);
    chk("x0_locker", 32'(o_lock), 32'd1);
    chk("x0_pcstall", 32'(o_pcs), 32'd0);

    // Hazard coinciding with a taken branch: flush, no replay.
    sel_seen = 0;
    step(5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 32'h3333_3333);
    step(5'd7, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b1, 32'h4444_4444);
    chk("br_flush", 32'(o_fl), 32'd1);
    idle_step();
    chk("br_flush_once", 32'(o_fl), 32'd0);
    chk("br_no_replay", 32'(sel_seen), 32'd0);

    // Reset asserted in the middle of a replay.
    step(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
    step(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 32'h0);
    bus.aluIsLoad = 0; bus.icacheValid = 1; bus.icacheData = 32'h5555_5555;
    #1;
    chk("rr_replay_select", 32'(bus.select), 32'd1);
    do_reset("rr_reset");
    #1;
    chk("rr_release_nextinst", bus.nextInst, 32'd0);
    chk("rr_release_locker", 32'(bus.locker), 32'd1);
    chk("rr_release_select", 32'(bus.select), 32'd0);
    @(negedge clk);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
           5'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), $urandom);
    end

`ifdef LOCK_STALL_COUNT_EN
    // Drive the counter up to 16'hFFFE, then past it.
    guard = 0;
    while (m_cnt < 65534 && guard < 70000) begin
      step(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
      guard++;
    end
    chk("sat_reached_fffe", 32'(bus.stallCount), 32'h0000_FFFE);
    for (int i = 0; i < 4; i++) step(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("sat_hold", 32'(bus.stallCount), 32'h0000_FFFF);
`else
    guard = 0;
    for (int i = 0; i < 4; i++) step(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("count_absent", 32'(bus.stallCount) + 32'(guard), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
